// File: rtl/adc_fifo_readout_pkg.sv
// Shared definitions for the ADC FIFO readout framer: state encoding and frame constants.
package adc_fifo_readout_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LEN_HI,
      LEN_LO,
      FETCH,
      WAIT,
      SEND,
      CKSUM
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hAC;
   localparam int         LEN_W_DEF      = 16;
   // Sync, length high, length low and checksum surround the payload.
   localparam int         FRAME_OVERHEAD = 4;

endpackage

// File: rtl/adc_fifo_readout.sv
// Frames FIFO samples as sync/len_hi/len_lo/payload/checksum bytes; pads with zeros on FIFO underrun.
// First read 1 cycle after the length-low transfer, byte presented 2 cycles after each read; holds on tx_ready_i low.
module adc_fifo_readout
   import adc_fifo_readout_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
   parameter int         LEN_W         = LEN_W_DEF,
   parameter int         EMPTY_TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic             abort_i,
   input  logic             fifo_empty_i,
   input  logic [7:0]       fifo_data_i,
   output logic             fifo_rd_en_o,
   output logic [7:0]       tx_data_o,
   output logic             tx_valid_o,
   input  logic             tx_ready_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             underrun_o,
   output logic [LEN_W-1:0] bytes_sent_o
);

   localparam int            TO_W    = $clog2(EMPTY_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(EMPTY_TIMEOUT - 1);

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] remaining;
   logic [LEN_W-1:0] bytes_sent;
   logic [7:0]       cksum;
   logic [7:0]       hold;
   logic [TO_W-1:0]  to_cnt;
   logic             pad_mode;
   logic             underrun;
   logic             done_q;
   logic             xfer;

   assign xfer = tx_valid_o & tx_ready_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      tx_valid_o   = 1'b0;
      tx_data_o    = 8'h00;
      fifo_rd_en_o = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = HDR;
         end
         HDR: begin
            tx_valid_o = 1'b1;
            tx_data_o  = SYNC_BYTE;
            if (tx_ready_i) state_nxt = LEN_HI;
         end
         LEN_HI: begin
            tx_valid_o = 1'b1;
            tx_data_o  = len_q[15:8];
            if (tx_ready_i) state_nxt = LEN_LO;
         end
         LEN_LO: begin
            tx_valid_o = 1'b1;
            tx_data_o  = len_q[7:0];
            if (tx_ready_i) state_nxt = (len_q == '0) ? CKSUM : FETCH;
         end
         FETCH: begin
            if (!fifo_empty_i) begin
               fifo_rd_en_o = 1'b1;
               state_nxt    = WAIT;
            end else if (to_cnt == TO_LAST) begin
               state_nxt = SEND;
            end
         end
         WAIT: begin
            state_nxt = SEND;
         end
         SEND: begin
            tx_valid_o = 1'b1;
            tx_data_o  = hold;
            if (tx_ready_i) begin
               if (remaining == LEN_W'(1)) state_nxt = CKSUM;
               else if (pad_mode)         state_nxt = SEND;
               else                        state_nxt = FETCH;
            end
         end
         CKSUM: begin
            tx_valid_o = 1'b1;
            tx_data_o  = cksum;
            if (tx_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort wins over everything, including a byte that would otherwise transfer this cycle.
      if (abort_i) begin
         state_nxt    = IDLE;
         tx_valid_o   = 1'b0;
         fifo_rd_en_o = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_q      <= '0;
         remaining  <= '0;
         bytes_sent <= '0;
         cksum      <= 8'h00;
         hold       <= 8'h00;
         to_cnt     <= '0;
         pad_mode   <= 1'b0;
         underrun   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!abort_i) begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     len_q      <= len_i;
                     remaining  <= len_i;
                     bytes_sent <= '0;
                     cksum      <= 8'h00;
                     hold       <= 8'h00;
                     to_cnt     <= '0;
                     pad_mode   <= 1'b0;
                     underrun   <= 1'b0;
                  end
               end
               FETCH: begin
                  if (!fifo_empty_i) begin
                     to_cnt <= '0;
                  end else if (to_cnt == TO_LAST) begin
                     to_cnt   <= '0;
                     underrun <= 1'b1;
                     pad_mode <= 1'b1;
                     hold     <= 8'h00;
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
               WAIT: begin
                  hold <= fifo_data_i;
               end
               SEND: begin
                  if (xfer) begin
                     cksum      <= cksum + hold;
                     remaining  <= remaining - LEN_W'(1);
                     bytes_sent <= bytes_sent + LEN_W'(1);
                  end
               end
               CKSUM: begin
                  if (xfer) done_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy_o       = (state != IDLE);
   assign done_o       = done_q;
   assign underrun_o   = underrun;
   assign bytes_sent_o = bytes_sent;

endmodule

// File: tb/tb_adc_fifo_readout.sv
// Bench for adc_fifo_readout: directed and randomized frames checked against a byte-list frame model.
module tb_adc_fifo_readout;
   import adc_fifo_readout_pkg::*;

   localparam int LW  = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start_i;
   logic [LW-1:0] len_i;
   logic          abort_i;
   logic          fifo_empty_i;
   logic [7:0]    fifo_data_i;
   logic          fifo_rd_en_o;
   logic [7:0]    tx_data_o;
   logic          tx_valid_o;
   logic          tx_ready_i;
   logic          busy_o;
   logic          done_o;
   logic          underrun_o;
   logic [LW-1:0] bytes_sent_o;

   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;
   logic [7:0] pushed [$];
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   assign fifo_empty_i = (rd_ptr == wr_ptr);

   // FIFO read port: data valid exactly one cycle after the strobe, junk otherwise.
   always @(posedge clk) begin
      if (fifo_rd_en_o) begin
         fifo_data_i <= mem[rd_ptr];
         rd_ptr      <= rd_ptr + 8'd1;
      end else begin
         fifo_data_i <= 8'($urandom);
      end
   end

   adc_fifo_readout #(.EMPTY_TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_i      (start_i),
      .len_i        (len_i),
      .abort_i      (abort_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .tx_data_o    (tx_data_o),
      .tx_valid_o   (tx_valid_o),
      .tx_ready_i   (tx_ready_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .underrun_o   (underrun_o),
      .bytes_sent_o (bytes_sent_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 8'd1;
      pushed.push_back(b);
   endtask

   task automatic flush();
      wr_ptr = rd_ptr;
      pushed.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  busy_o,       0);
      chk({tag, "_valid"}, tx_valid_o,   0);
      chk({tag, "_data"},  tx_data_o,    0);
      chk({tag, "_rd"},    fifo_rd_en_o, 0);
      chk({tag, "_done"},  done_o,       0);
      chk({tag, "_undr"},  underrun_o,   0);
      chk({tag, "_sent"},  bytes_sent_o, 0);
   endtask

   // mode 0: ready always high, 1: random ready, 2: five stall cycles per byte.
   // abort_at >= 0 aborts while the byte with that frame index is being offered.
   task automatic run_frame(input int len, input int mode, input int abort_at, input bit spam);
      logic [7:0] got [$];
      logic [7:0] exp [$];
      logic [7:0] b, sum, pd;
      int         k, nrd, ndone, hdr_cyc, rd_cyc, dat_cyc, stall, idx, nexp;
      bit         aborted, fin, pv, pr;
      k = pushed.size();
      nrd = 0; ndone = 0; hdr_cyc = -1; rd_cyc = -1; dat_cyc = -1; stall = 0;
      aborted = 0; fin = 0; pv = 0; pr = 0; pd = 8'h00;
      @(negedge clk);
      start_i = 1'b1; len_i = LW'(len); tx_ready_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0; len_i = LW'($urandom);
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         start_i = 1'b0;
         if (fifo_rd_en_o) begin
            nrd++;
            if (rd_cyc < 0) rd_cyc = cyc;
            chk("rd_while_empty", fifo_empty_i, 0);
         end
         if (pv && !pr) begin
            chk("stall_valid", tx_valid_o, 1);
            chk("stall_data", tx_data_o, pd);
         end
         if (done_o) begin
            ndone++;
            fin = 1;
         end else begin
            case (mode)
               0:       tx_ready_i = 1'b1;
               1:       tx_ready_i = 1'($urandom);
               default: tx_ready_i = (stall >= 5);
            endcase
            if (tx_valid_o && got.size() == 3 && dat_cyc < 0) dat_cyc = cyc;
            if (abort_at >= 0 && tx_valid_o && got.size() == abort_at) begin
               abort_i    = 1'b1;
               tx_ready_i = 1'b1;
               aborted    = 1;
            end else if (tx_valid_o && tx_ready_i) begin
               got.push_back(tx_data_o);
               if (got.size() == 3) hdr_cyc = cyc;
               stall = 0;
            end else if (tx_valid_o) begin
               stall++;
            end
            pv = tx_valid_o; pr = tx_ready_i; pd = tx_data_o;
            if (spam && busy_o) begin
               start_i = 1'($urandom);
               len_i   = LW'($urandom);
            end
            @(negedge clk);
            if (aborted) begin
               abort_i = 1'b0;
               fin     = 1;
            end
         end
      end
      start_i = 1'b0;
      tx_ready_i = 1'b0;
      chk("frame_finished", fin, 1);
      chk("done_count", ndone, aborted ? 0 : 1);
      if (aborted) begin
         idx = abort_at - 3;
         chk("abort_busy", busy_o, 0);
         chk("abort_valid", tx_valid_o, 0);
         chk("abort_rd", fifo_rd_en_o, 0);
         chk("abort_bytes_sent", bytes_sent_o, idx);
         chk("abort_underrun", underrun_o, (idx >= k) ? 1 : 0);
      end else begin
         exp.push_back(8'hAC);
         exp.push_back(8'(len >> 8));
         exp.push_back(8'(len));
         sum = 8'h00;
         for (int i = 0; i < len; i++) begin
            b = (i < k) ? pushed[i] : 8'h00;
            exp.push_back(b);
            sum = sum + b;
         end
         exp.push_back(sum);
         chk("frame_size", got.size(), len + FRAME_OVERHEAD);
         nexp = exp.size();
         for (int i = 0; i < nexp && i < got.size(); i++)
            chk($sformatf("byte%0d", i), got[i], exp[i]);
         chk("reads", nrd, (len < k) ? len : k);
         chk("underrun", underrun_o, (k < len) ? 1 : 0);
         chk("bytes_sent", bytes_sent_o, len);
         chk("idle_at_done", busy_o, 0);
         if (len > 0 && k > 0) begin
            chk("rd_latency", rd_cyc, hdr_cyc + 1);
            chk("data_latency", dat_cyc, rd_cyc + 2);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_extra_done", done_o, 0);
      end
      flush();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, k;
      reset_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; tx_ready_i = 1'b0; len_i = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy_o, 0);

      push(8'h11); push(8'h22); push(8'h33);
      run_frame(3, 0, -1, 0);

      run_frame(0, 0, -1, 0);

      push(8'h05);
      run_frame(4, 0, -1, 0);

      push(8'($urandom)); push(8'($urandom));
      run_frame(2, 2, -1, 0);

      push(8'h5A);
      run_frame(4, 0, 4, 0);
      push(8'h77);
      run_frame(1, 0, -1, 0);

      run_frame(260, 0, -1, 0);

      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(1, 20);
         k   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len + $urandom_range(0, 3);
         for (int i = 0; i < k; i++) push(8'($urandom));
         run_frame(len, 1, -1, 1);
      end

      for (int i = 0; i < 6; i++) push(8'($urandom));
      @(negedge clk);
      start_i = 1'b1; len_i = LW'(6); tx_ready_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("midreset");
      @(negedge clk);
      reset_n = 1'b1; tx_ready_i = 1'b0;
      flush();

      for (int i = 0; i < 3; i++) push(8'($urandom));
      run_frame(3, 1, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
